// File: rtl/pixel_row_readout_pkg.sv
// Shared configuration and types for the pixel row readout stage.
// Defaults match the sensor's default geometry.
package pixel_row_readout_pkg;
   localparam int PIXEL_ARRAY_WIDTH  = 4;
   localparam int PIXEL_ARRAY_HEIGHT = 4;
   localparam int PIXEL_BITS         = 8;
   localparam int ROW_IDX_BITS       = $clog2(PIXEL_ARRAY_HEIGHT);
   localparam int COL_IDX_BITS       = $clog2(PIXEL_ARRAY_WIDTH);

   typedef logic [PIXEL_BITS-1:0] pixel_t;
   typedef enum logic {RO_IDLE, RO_STREAM} readout_state_t;
endpackage

// File: rtl/pixel_row_readout_if.sv
// Pixel stream valid/ready bus with row/column/framing tags.
interface pixel_row_readout_if #(
   parameter int PIXEL_ARRAY_WIDTH  = 4,
   parameter int PIXEL_ARRAY_HEIGHT = 4,
   parameter int PIXEL_BITS         = 8
);
   logic [PIXEL_BITS-1:0]                 pixel_data;
   logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0] pixel_row;
   logic [$clog2(PIXEL_ARRAY_WIDTH)-1:0]  pixel_col;
   logic                                  pixel_sof;
   logic                                  pixel_eol;
   logic                                  pixel_valid;
   logic                                  pixel_ready;

   modport master (output pixel_data, pixel_row, pixel_col, pixel_sof, pixel_eol,
                   pixel_valid, input pixel_ready);
   modport slave  (input pixel_data, pixel_row, pixel_col, pixel_sof, pixel_eol,
                   pixel_valid, output pixel_ready);
endinterface

// File: rtl/pixel_row_readout_onehot_row_encoder.sv
// Encodes the one-hot row select into a binary row index and flags
// selects that are not exactly one-hot.
module onehot_row_encoder #(
   parameter int PIXEL_ARRAY_HEIGHT = 4,
   localparam int RW = $clog2(PIXEL_ARRAY_HEIGHT)
) (
   input  logic [PIXEL_ARRAY_HEIGHT-1:0] sel_i,
   output logic [RW-1:0]                 index_o,
   output logic                          onehot_o
);
   always_comb begin
      index_o = '0;
      for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++)
         if (sel_i[i]) index_o = index_o | RW'(i);
      onehot_o = (sel_i != '0) &&
                 ((sel_i & (sel_i - PIXEL_ARRAY_HEIGHT'(1))) == '0);
   end
endmodule

// File: rtl/pixel_row_readout.sv
// Captures converted pixel rows into a two-entry ping-pong buffer and streams
// them one pixel per beat with row/column/framing tags.
module pixel_row_readout
   import pixel_row_readout_pkg::*;
#(
   parameter int PIXEL_ARRAY_WIDTH  = pixel_row_readout_pkg::PIXEL_ARRAY_WIDTH,
   parameter int PIXEL_ARRAY_HEIGHT = pixel_row_readout_pkg::PIXEL_ARRAY_HEIGHT,
   parameter int PIXEL_BITS         = pixel_row_readout_pkg::PIXEL_BITS
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [PIXEL_ARRAY_HEIGHT-1:0]           sensor_row_select_i,
   input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] row_data_i,
   input  logic                                    row_data_valid_i,
   input  logic                                    status_clear_i,
   pixel_row_readout_if.master                     px,
   output logic                                    overflow_o,
   output logic                                    row_error_o
);
   localparam int W  = PIXEL_ARRAY_WIDTH;
   localparam int RW = $clog2(PIXEL_ARRAY_HEIGHT);
   localparam int CW = $clog2(PIXEL_ARRAY_WIDTH);
   localparam int DW = PIXEL_ARRAY_WIDTH*PIXEL_BITS;

   logic [1:0][DW-1:0] buf_data_q;
   logic [1:0][RW-1:0] buf_row_q;
   logic [1:0]         full_q;
   logic               wr_ptr_q, rd_ptr_q;
   readout_state_t     state_q;
   logic [CW-1:0]      col_q;
   logic [RW-1:0]      row_q;
   logic [PIXEL_BITS-1:0] data_q;
   logic               valid_q, sof_q, eol_q, overflow_q, row_error_q;

   logic [RW-1:0] enc_idx;
   logic          enc_onehot;

   onehot_row_encoder #(.PIXEL_ARRAY_HEIGHT(PIXEL_ARRAY_HEIGHT)) u_enc (
      .sel_i    (sensor_row_select_i),
      .index_o  (enc_idx),
      .onehot_o (enc_onehot)
   );

   logic          err_new, ovf_new, capture, xfer, last, free;
   logic          ld_d, idle_d;
   logic [DW-1:0] ld_word_d;
   logic [RW-1:0] ld_row_d;
   logic [CW-1:0] ld_col_d;

   assign err_new = row_data_valid_i & ~enc_onehot;
   assign ovf_new = row_data_valid_i & enc_onehot & full_q[wr_ptr_q];
   assign capture = row_data_valid_i & enc_onehot & ~full_q[wr_ptr_q];
   assign xfer    = valid_q & px.pixel_ready;
   assign last    = (col_q == CW'(W-1));
   assign free    = (state_q == RO_STREAM) & xfer & last;

   // Selects the beat to present after this edge; idle->stream bypasses the
   // buffer so the first beat appears in the cycle after the capture edge.
   always_comb begin
      ld_d      = 1'b0;
      idle_d    = 1'b0;
      ld_word_d = buf_data_q[rd_ptr_q];
      ld_row_d  = buf_row_q[rd_ptr_q];
      ld_col_d  = '0;
      case (state_q)
         RO_IDLE: begin
            if (full_q[rd_ptr_q]) begin
               ld_d = 1'b1;
            end else if (capture && (wr_ptr_q == rd_ptr_q)) begin
               ld_d      = 1'b1;
               ld_word_d = row_data_i;
               ld_row_d  = enc_idx;
            end
         end
         RO_STREAM: begin
            if (xfer && last) begin
               if (full_q[~rd_ptr_q]) begin
                  ld_d      = 1'b1;
                  ld_word_d = buf_data_q[~rd_ptr_q];
                  ld_row_d  = buf_row_q[~rd_ptr_q];
               end else begin
                  idle_d = 1'b1;
               end
            end else if (xfer) begin
               ld_d     = 1'b1;
               ld_col_d = col_q + 1'b1;
            end
         end
         default: idle_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_data_q  <= '0;
         buf_row_q   <= '0;
         full_q      <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         state_q     <= RO_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         sof_q       <= 1'b0;
         eol_q       <= 1'b0;
         overflow_q  <= 1'b0;
         row_error_q <= 1'b0;
      end else begin
         row_error_q <= (row_error_q & ~status_clear_i) | err_new;
         overflow_q  <= (overflow_q & ~status_clear_i) | ovf_new;
         // Capture targets an empty buffer and free targets a full one, so the
         // two full_q writes below never hit the same bit.
         if (capture) begin
            buf_data_q[wr_ptr_q] <= row_data_i;
            buf_row_q[wr_ptr_q]  <= enc_idx;
            full_q[wr_ptr_q]     <= 1'b1;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (free) begin
            full_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q         <= ~rd_ptr_q;
         end
         if (ld_d) begin
            state_q <= RO_STREAM;
            valid_q <= 1'b1;
            data_q  <= ld_word_d[int'(ld_col_d)*PIXEL_BITS +: PIXEL_BITS];
            row_q   <= ld_row_d;
            col_q   <= ld_col_d;
            sof_q   <= (ld_row_d == '0) && (ld_col_d == '0);
            eol_q   <= (ld_col_d == CW'(W-1));
         end else if (idle_d) begin
            state_q <= RO_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
         end
      end
   end

   assign px.pixel_data  = data_q;
   assign px.pixel_row   = row_q;
   assign px.pixel_col   = col_q;
   assign px.pixel_sof   = sof_q;
   assign px.pixel_eol   = eol_q;
   assign px.pixel_valid = valid_q;
   assign overflow_o     = overflow_q;
   assign row_error_o    = row_error_q;
endmodule

// File: tb/tb_pixel_row_readout.sv
// Randomized and directed stimulus for pixel_row_readout, checked cycle by
// cycle against a row-queue reference model.
module tb_pixel_row_readout;
   import pixel_row_readout_pkg::*;
   localparam int W = 4;
   localparam int H = 4;
   localparam int B = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [H-1:0]   sel = '0;
   logic [W*B-1:0] rdata = '0;
   logic strobe = 1'b0, clr = 1'b0, rdy = 1'b0;
   logic ovf, rerr;

   always #5 clk = ~clk;

   pixel_row_readout_if #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H),
                          .PIXEL_BITS(B)) px ();
   assign px.pixel_ready = rdy;

   pixel_row_readout #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H),
                       .PIXEL_BITS(B)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .sensor_row_select_i (sel),
      .row_data_i          (rdata),
      .row_data_valid_i    (strobe),
      .status_clear_i      (clr),
      .px                  (px.master),
      .overflow_o          (ovf),
      .row_error_o         (rerr)
   );

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: queue of accepted rows, the head being streamed.
   typedef struct { int row; logic [W*B-1:0] data; } mrow_t;
   mrow_t rq[$];
   int    mcol;
   bit    mvalid, movf, merr;

   task automatic model_reset();
      rq.delete();
      mcol = 0; mvalid = 0; movf = 0; merr = 0;
   endtask

   task automatic model_step();
      int pre_n = rq.size();
      bit x   = mvalid && rdy;
      bit fin = x && (mcol == W-1);
      bit oh  = ($countones(sel) == 1);
      int idx = 0;
      for (int i = 0; i < H; i++) if (sel[i]) idx = i;
      merr = (merr && !clr) || (strobe && !oh);
      movf = (movf && !clr) || (strobe && oh && pre_n == 2);
      if (x) begin
         if (fin) begin
            void'(rq.pop_front());
            mcol = 0;
         end else mcol++;
      end
      if (strobe && oh && pre_n < 2) rq.push_back('{row: idx, data: rdata});
      if (fin) mvalid = (pre_n == 2);
      else if (!mvalid) mvalid = (rq.size() > 0);
   endtask

   task automatic compare();
      chk("valid", px.pixel_valid, mvalid);
      if (mvalid) begin
         chk("data", px.pixel_data, rq[0].data[mcol*B +: B]);
         chk("row",  px.pixel_row, rq[0].row);
         chk("col",  px.pixel_col, mcol);
         chk("sof",  px.pixel_sof, (rq[0].row == 0) && (mcol == 0));
         chk("eol",  px.pixel_eol, mcol == W-1);
      end else begin
         chk("sof_idle", px.pixel_sof, 0);
         chk("eol_idle", px.pixel_eol, 0);
      end
      chk("overflow",  ovf, movf);
      chk("row_error", rerr, merr);
   endtask

   // Called at a negedge: drive inputs, step the model on the edge, check after.
   task automatic cyc(input bit s, input logic [H-1:0] sl, input logic [W*B-1:0] d,
                      input bit r, input bit c);
      strobe = s; sel = sl; rdata = d; rdy = r; clr = c;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) cyc(0, '0, '0, r, 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, px.pixel_valid, 0);
      chk({tag, "_data"},  px.pixel_data, 0);
      chk({tag, "_col"},   px.pixel_col, 0);
      chk({tag, "_sof"},   px.pixel_sof, 0);
      chk({tag, "_ovf"},   ovf, 0);
      chk({tag, "_err"},   rerr, 0);
   endtask

   initial begin
      bit pat[4] = '{1, 0, 0, 1};
      model_reset();
      #1 check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1: single row, ready held high
      cyc(1, 4'b0001, 32'h13121110, 1, 0);
      idle(5, 1);
      // 2: back-to-back rows 1 and 2
      cyc(1, 4'b0010, $urandom, 1, 0);
      cyc(1, 4'b0100, $urandom, 1, 0);
      idle(10, 1);
      // 3: overflow with sink stalled, then drain and clear
      cyc(1, 4'b0001, $urandom, 0, 0);
      cyc(1, 4'b0010, $urandom, 0, 0);
      cyc(1, 4'b0100, $urandom, 0, 0);
      idle(3, 0);
      idle(10, 1);
      cyc(0, '0, '0, 1, 1);
      idle(2, 1);
      // 4: non-one-hot selects
      cyc(1, 4'b0110, $urandom, 1, 0);
      cyc(1, 4'b0000, $urandom, 1, 0);
      idle(3, 1);
      cyc(0, '0, '0, 1, 1);
      // 5: ready toggling 1,0,0,1
      cyc(1, 4'b0001, 32'h13121110, 1, 0);
      for (int i = 0; i < 14; i++) cyc(0, '0, '0, pat[i % 4], 0);
      // 6: reset mid-row at col 2
      cyc(1, 4'b0001, $urandom, 1, 0);
      idle(2, 1);
      chk("pre_rst_col", px.pixel_col, 2);
      #2 rst_n = 1'b0;
      #1 check_zero("mid_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle(2, 1);
      cyc(1, 4'b1000, $urandom, 1, 0);
      idle(5, 1);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         logic [H-1:0] s;
         s = ($urandom_range(0, 7) == 0) ? H'($urandom) : H'(1 << $urandom_range(0, H-1));
         cyc($urandom_range(0, 2) == 0, s, $urandom, $urandom_range(0, 3) != 0,
             $urandom_range(0, 15) == 0);
      end
      idle(12, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
